target_report_scheduler: RTL and testbench
==========================================

Name: target_report_scheduler

Overview:
- Frame-level sequencer sitting behind the eye-target detector.
- Snapshots the per-slot bounding boxes {top,down,left,right} once per frame, after the detector has published them on vsync rise.
- Drops slots that are disabled or empty, and serialises the rest in ascending slot order onto a valid/ready stream for the UART/overlay consumers.
- Tracks frame IDs and counts frames lost because the stream had not drained in time.

Parameters:
- N_SLOT, 10, number of target slots (max 15; slot code 4'hF is reserved).
- BOX_W, 48, bits per slot box {top[11:0],down[11:0],left[11:0],right[11:0]}.
- CAP_DLY, 2, clocks from the sampled vsync rising edge to the snapshot; range 1..15.
- FID_W, 8, frame ID width.

Ports:
- clk  in  1  pixel/cmos clock.
- rst  in  1  asynchronous reset, active-high.
- per_frame_vsync  in  1  frame valid, same signal the detector sees.
- box_flat  in  N_SLOT*BOX_W  slot i occupies bits [i*BOX_W +: BOX_W].
- en  in  N_SLOT  per-slot report enable.
- m_valid  out  1  stream beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  FID_W+4+4+BOX_W (64)  {frame_id, slot[3:0], 4'b0, box}.
- m_last  out  1  final beat of the frame.
- busy  out  1  state != IDLE.
- overrun_cnt  out  8  saturating count of dropped frames.
- frame_id  out  FID_W  ID of the most recent detected frame.

Behaviour:
- Reset values: m_valid=0, m_last=0, m_data=0, busy=0, overrun_cnt=0, frame_id=0, state=IDLE, snapshot and pending mask cleared.
- Asserting rst mid-beat drops m_valid immediately; the partial frame is lost.
- Edge detect:
  - vsync_r registers per_frame_vsync.
  - Rising edge sampled at cycle T when per_frame_vsync=1 and vsync_r=0.
  - frame_id increments (wraps) at T+1 on every edge, including dropped frames.
- FSM states: IDLE, WAIT, LOAD, SEND.
- IDLE: on edge at T go to WAIT and load delay counter = CAP_DLY-1.
- WAIT: decrement the counter; at 0 go to LOAD.
- LOAD, at cycle T+CAP_DLY:
  - Capture box_flat into the snapshot; latch the current frame_id into the beat ID.
  - pending[i] = en[i] && box_i != 0.
  - If pending==0, return to IDLE with no beats (see optional feature).
  - Otherwise go to SEND.
- SEND:
  - idx = lowest set bit of pending.
  - Drive m_valid=1, m_data={fid, idx, 4'b0, snap[idx]}, m_last=((pending & ~onehot(idx))==0).
  - First m_valid appears at T+CAP_DLY+1.
  - On m_valid&&m_ready: clear pending[idx]. Present the next beat the following cycle (m_valid stays high, so up to 1 beat/clk); if this was the m_last beat, drop m_valid and go to IDLE.
- Handshake rules:
  - Once m_valid=1, m_data and m_last hold stable until accepted.
  - m_valid never deasserts without acceptance, except on reset.
  - m_ready is ignored while m_valid=0.
- Overrun:
  - An edge seen in any state other than IDLE does not restart the FSM; the current frame completes.
  - overrun_cnt increments, saturating at 255.
  - An edge in the same cycle the last beat is accepted counts as overrun. IDLE is only entered the next cycle.
- Snapshot isolation: box_flat and en changes after LOAD do not affect beats of the current frame.

Optional Feature:
- Macro: TARGET_REPORT_EMPTY_BEAT_EN.
- Defined: a frame with pending==0 after LOAD emits exactly one marker beat, m_data={fid, 4'hF, 4'b0, 48'd0}, m_last=1, using the same handshake. The FSM goes LOAD->SEND for the marker, then IDLE.
- Undefined: empty frames emit nothing and LOAD returns directly to IDLE.

Test Plan:
- Default params, en=10'h3FF, boxes nonzero in slots 0,3,9, m_ready=1 → rising vsync at T; beats at T+3,T+4,T+5 with slots 0,3,9; m_last only on slot 9; frame_id field =1.
- Same frame, m_ready low for 5 cycles at the first beat → m_valid held high, m_data unchanged for all 5 cycles; beats then drain in order.
- en=10'h3F7 (slot 3 disabled), boxes in 0,3,9 → only slots 0 and 9 emitted; slot 9 carries m_last.
- Frame ID wrap: 256 frames with slot 0 = {12'd10,12'd20,12'd30,12'd40} → frame_id sequence ..., 255, 0; box field = 48'h00A_014_01E_028.
- Overrun: m_ready=0, second vsync edge while in SEND → overrun_cnt=1, no restart, frame_id=2. After release, the frame-1 beats drain; the next edge starts frame 3 normally.
- All boxes zero → no beat and busy=0 by T+CAP_DLY+1. With TARGET_REPORT_EMPTY_BEAT_EN: a single beat with slot 4'hF, m_last=1. rst asserted mid-SEND → m_valid=0 the same cycle, overrun_cnt=0.

Source files
------------

// File: rtl/target_report_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : target_report_scheduler
// Purpose  : Snapshots detector slot boxes once per frame and serialises the
//            enabled, non-empty slots onto a valid/ready stream.
// Options  : TARGET_REPORT_EMPTY_BEAT_EN - empty frames emit one 4'hF marker.
// Revision : 1.0 - initial release
// ============================================================================
module target_report_scheduler #(
    parameter int N_SLOT  = 10,
    parameter int BOX_W   = 48,
    parameter int CAP_DLY = 2,
    parameter int FID_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      per_frame_vsync,
    input  logic [N_SLOT*BOX_W-1:0]   box_flat,
    input  logic [N_SLOT-1:0]         en,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [FID_W+8+BOX_W-1:0]  m_data,
    output logic                      m_last,
    output logic                      busy,
    output logic [7:0]                overrun_cnt,
    output logic [FID_W-1:0]          frame_id
);

    localparam logic [1:0]        S_IDLE     = 2'd0;
    localparam logic [1:0]        S_WAIT     = 2'd1;
    localparam logic [1:0]        S_LOAD     = 2'd2;
    localparam logic [1:0]        S_SEND     = 2'd3;
    localparam logic [3:0]        DLY_INIT   = 4'(CAP_DLY - 1);
    localparam logic [3:0]        EMPTY_SLOT = 4'hF;
    localparam logic [N_SLOT-1:0] SLOT_ONE   = N_SLOT'(1);
    localparam logic [FID_W-1:0]  FID_ONE    = FID_W'(1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [N_SLOT-1:0] pending_q, pending_d;
    logic              empty_q, empty_d;
    logic              vsync_q;
    logic [FID_W-1:0]  fid_q;
    logic [FID_W-1:0]  beat_fid_q;
    logic [7:0]        ovr_q;
    logic [BOX_W-1:0]  snap_q [N_SLOT];

    logic              w_edge;
    logic [N_SLOT-1:0] w_load_mask;
    logic [3:0]        w_idx;
    logic [N_SLOT-1:0] w_rest;

    assign w_edge = per_frame_vsync & ~vsync_q;

    always_comb begin
        w_load_mask = '0;
        for (int i = 0; i < N_SLOT; i++) begin
            w_load_mask[i] = en[i] && (box_flat[i*BOX_W +: BOX_W] != '0);
        end
    end

    // Lowest pending slot goes first, so scan from the top down.
    always_comb begin
        w_idx = 4'd0;
        for (int i = N_SLOT - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                w_idx = 4'(i);
            end
        end
    end

    assign w_rest = pending_q & ~(SLOT_ONE << w_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            pending_q <= '0;
            empty_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            empty_q   <= empty_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        empty_d   = empty_q;
        case (state_q)
            S_IDLE: begin
                if (w_edge) begin
                    if (CAP_DLY == 1) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = DLY_INIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                pending_d = w_load_mask;
                empty_d   = 1'b0;
                if (w_load_mask == '0) begin
`ifdef TARGET_REPORT_EMPTY_BEAT_EN
                    state_d = S_SEND;
                    empty_d = 1'b1;
`else
                    state_d = S_IDLE;
`endif
                end else begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (m_ready) begin
                    if (empty_q) begin
                        empty_d = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        pending_d[w_idx] = 1'b0;
                        if (w_rest == '0) begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame ID and overrun tracking see every edge, whatever the FSM is doing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q    <= 1'b0;
            fid_q      <= '0;
            beat_fid_q <= '0;
            ovr_q      <= 8'd0;
            for (int i = 0; i < N_SLOT; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            vsync_q <= per_frame_vsync;
            if (w_edge) begin
                fid_q <= fid_q + FID_ONE;
                if (state_q != S_IDLE && ovr_q != 8'hFF) begin
                    ovr_q <= ovr_q + 8'd1;
                end
            end
            if (state_q == S_LOAD) begin
                beat_fid_q <= fid_q;
                for (int i = 0; i < N_SLOT; i++) begin
                    snap_q[i] <= box_flat[i*BOX_W +: BOX_W];
                end
            end
        end
    end

    always_comb begin
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = '0;
        if (state_q == S_SEND) begin
            m_valid = 1'b1;
            if (empty_q) begin
                m_last = 1'b1;
                m_data = {beat_fid_q, EMPTY_SLOT, 4'h0, {BOX_W{1'b0}}};
            end else begin
                m_last = (w_rest == '0);
                m_data = {beat_fid_q, w_idx, 4'h0, snap_q[w_idx]};
            end
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign overrun_cnt = ovr_q;
    assign frame_id    = fid_q;

endmodule
`default_nettype wire

// File: tb/tb_target_report_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_target_report_scheduler
// Purpose  : Directed + random stimulus against a queue-based frame model.
// Options  : TARGET_REPORT_EMPTY_BEAT_EN - model expects the empty-frame marker.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_target_report_scheduler;

    localparam int N_SLOT  = 10;
    localparam int BOX_W   = 48;
    localparam int CAP_DLY = 2;
    localparam int FID_W   = 8;
    localparam int DW      = FID_W + 8 + BOX_W;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     per_frame_vsync = 1'b0;
    logic [N_SLOT*BOX_W-1:0]  box_flat = '0;
    logic [N_SLOT-1:0]        en = '0;
    logic                     m_ready = 1'b0;
    logic                     m_valid;
    logic [DW-1:0]            m_data;
    logic                     m_last;
    logic                     busy;
    logic [7:0]               overrun_cnt;
    logic [FID_W-1:0]         frame_id;

    target_report_scheduler #(
        .N_SLOT (N_SLOT),
        .BOX_W  (BOX_W),
        .CAP_DLY(CAP_DLY),
        .FID_W  (FID_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .per_frame_vsync(per_frame_vsync),
        .box_flat       (box_flat),
        .en             (en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .busy           (busy),
        .overrun_cnt    (overrun_cnt),
        .frame_id       (frame_id)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a frame is "active" from its edge until its last beat
    // is accepted; its beat list is built from the inputs CAP_DLY cycles on.
    logic [DW-1:0] exp_q [$];
    int  cyc     = 0;
    bit  act     = 1'b0;
    bit  sending = 1'b0;
    int  cap_at  = 0;
    int  m_fid   = 0;
    int  m_ovr   = 0;
    bit  vs_prev = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        bit a, exp_v;
        logic [BOX_W-1:0] b;
        a     = act;
        exp_v = sending && (exp_q.size() > 0);
        chk("busy", 64'(busy), 64'(a));
        chk("frame_id", 64'(frame_id), 64'(m_fid % 256));
        chk("overrun_cnt", 64'(overrun_cnt), 64'(m_ovr));
        chk("m_valid", 64'(m_valid), 64'(exp_v));
        if (exp_v) begin
            chk("m_data", m_data, exp_q[0]);
            chk("m_last", 64'(m_last), 64'(exp_q.size() == 1));
            if (m_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    act     = 1'b0;
                    sending = 1'b0;
                end
            end
        end
        if (a && !sending && cyc == cap_at) begin
            for (int i = 0; i < N_SLOT; i++) begin
                b = box_flat[i*BOX_W +: BOX_W];
                if (en[i] && b != '0) exp_q.push_back({8'(m_fid), 4'(i), 4'h0, b});
            end
`ifdef TARGET_REPORT_EMPTY_BEAT_EN
            if (exp_q.size() == 0) exp_q.push_back({8'(m_fid), 4'hF, 4'h0, 48'h0});
`endif
            if (exp_q.size() == 0) act = 1'b0;
            else sending = 1'b1;
        end
        if (per_frame_vsync && !vs_prev) begin
            if (a) begin
                if (m_ovr < 255) m_ovr++;
            end else begin
                act    = 1'b1;
                cap_at = cyc + CAP_DLY;
            end
            m_fid = (m_fid + 1) % 256;
        end
        vs_prev = per_frame_vsync;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic pulse(input int hi);
        per_frame_vsync = 1'b1;
        repeat (hi) step();
        per_frame_vsync = 1'b0;
        step();
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((act || exp_q.size() > 0) && n < limit) begin
            step();
            n++;
        end
        chk("drain_done", 64'(act), 64'(0));
        step();
    endtask

    task automatic set_box(input int i, input logic [BOX_W-1:0] v);
        box_flat[i*BOX_W +: BOX_W] = v;
    endtask

    task automatic rand_boxes();
        for (int i = 0; i < N_SLOT; i++) begin
            if ($urandom_range(2) == 0) set_box(i, '0);
            else set_box(i, {16'($urandom), $urandom});
        end
        en = N_SLOT'($urandom);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_m_last", 64'(m_last), 64'(0));
        chk("rst_m_data", m_data, 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_overrun", 64'(overrun_cnt), 64'(0));
        chk("rst_frame_id", 64'(frame_id), 64'(0));
        rst = 1'b0;
        step();

        // Slots 0,3,9 populated, all enabled, always ready
        set_box(0, 48'h001_002_003_004);
        set_box(3, 48'h0A0_0B0_0C0_0D0);
        set_box(9, 48'hFFF_123_456_789);
        en      = 10'h3FF;
        m_ready = 1'b1;
        pulse(4);
        drain(50);

        // Back-pressure on the first beat for 5 cycles
        m_ready = 1'b0;
        pulse(1);
        step();
        chk("bp_first_valid", 64'(m_valid), 64'(1));
        chk("bp_first_slot", 64'(m_data[55:52]), 64'(0));
        repeat (5) step();
        m_ready = 1'b1;
        drain(50);

        // Slot 3 disabled
        en = 10'h3F7;
        pulse(2);
        drain(50);

        // Frame-ID wrap with a fixed slot-0 box
        box_flat = '0;
        en       = 10'h3FF;
        set_box(0, {12'd10, 12'd20, 12'd30, 12'd40});
        for (int k = 0; k < 256; k++) begin
            pulse(1);
            if (k == 255) begin
                step();
                chk("wrap_box", 64'(m_data[47:0]), 64'(48'h00A_014_01E_028));
            end
            drain(50);
        end

        // Overrun: second edge while stalled in SEND
        m_ready = 1'b0;
        set_box(5, 48'h555_555_555_555);
        pulse(1);
        repeat (3) step();
        pulse(1);
        step();
        chk("ovr_one", 64'(overrun_cnt), 64'(1));
        m_ready = 1'b1;
        drain(50);
        pulse(1);
        drain(50);

        // All boxes zero
        box_flat = '0;
        pulse(1);
        drain(50);

        // Snapshot isolation: inputs change right after LOAD
        rand_boxes();
        en = 10'h3FF;
        set_box(2, 48'h222_222_222_222);
        m_ready = 1'b0;
        pulse(1);
        step();
        step();
        rand_boxes();
        m_ready = 1'b1;
        drain(50);

        // Random traffic
        rand_boxes();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(5) == 0) per_frame_vsync = ~per_frame_vsync;
            m_ready = ($urandom_range(3) != 0);
            if ($urandom_range(9) == 0) rand_boxes();
            step();
        end
        per_frame_vsync = 1'b0;
        m_ready = 1'b1;
        drain(400);

        // Saturation, then reset mid-SEND
        box_flat = '0;
        set_box(0, 48'h0000_0000_0001);
        en      = 10'h001;
        m_ready = 1'b0;
        for (int k = 0; k < 262; k++) pulse(1);
        chk("ovr_sat", 64'(overrun_cnt), 64'(255));
        chk("pre_rst_valid", 64'(m_valid), 64'(1));
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(m_valid), 64'(0));
        chk("rst_mid_overrun", 64'(overrun_cnt), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        exp_q.delete();
        act     = 1'b0;
        sending = 1'b0;
        m_fid   = 0;
        m_ovr   = 0;
        vs_prev = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        m_ready = 1'b1;
        step();
        pulse(1);
        drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
